// File: rtl/fp_divider_seq_if.sv
// rtl/fp_divider_seq_if.sv - operand/result handshake bundle for the sequential fp divider
interface fp_divider_seq_if;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] Dividend;
   logic [31:0] Divisor;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] Output;
   logic        busy;

   modport master (
      output in_valid,
      output Dividend,
      output Divisor,
      output out_ready,
      input  in_ready,
      input  out_valid,
      input  Output,
      input  busy
   );

   modport slave (
      input  in_valid,
      input  Dividend,
      input  Divisor,
      input  out_ready,
      output in_ready,
      output out_valid,
      output Output,
      output busy
   );
endinterface

// File: rtl/fp_divider_seq.sv
// rtl/fp_divider_seq.sv - sequential IEEE-754 single-precision divider, radix-2 restoring
// Special operands resolve in the accept cycle; normal operands take 25 divide steps plus one normalise step.
module fp_divider_seq #(
   parameter logic [31:0] NAN_VALUE = 32'h7FC00000
) (
   input logic             clk,
   input logic             reset_n,
   fp_divider_seq_if.slave bus
);

   typedef enum logic [1:0] {
      IDLE,
      DIVIDE,
      NORM,
      DONE
   } state_t;

   state_t state;
   state_t state_nxt;

   logic        sign_r;
   logic [7:0]  ea_r;
   logic [7:0]  eb_r;
   logic [23:0] mb_r;
   logic [24:0] rem_r;
   logic [24:0] quo_r;
   logic [4:0]  cnt_r;
   logic [31:0] res_r;
   logic [31:0] out_r;
   logic        out_valid_r;

   // operand classification, exponent 0 means zero (denormals flushed)
   logic [7:0]  a_exp;
   logic [7:0]  b_exp;
   logic [22:0] a_frac;
   logic [22:0] b_frac;
   logic        a_nan;
   logic        b_nan;
   logic        a_inf;
   logic        b_inf;
   logic        a_zero;
   logic        b_zero;
   logic        sign_in;
   logic        spec_hit;
   logic [31:0] spec_val;

   always_comb begin
      a_exp    = bus.Dividend[30:23];
      b_exp    = bus.Divisor[30:23];
      a_frac   = bus.Dividend[22:0];
      b_frac   = bus.Divisor[22:0];
      sign_in  = bus.Dividend[31] ^ bus.Divisor[31];
      a_nan    = (a_exp == 8'hFF) && (a_frac != 23'h0);
      b_nan    = (b_exp == 8'hFF) && (b_frac != 23'h0);
      a_inf    = (a_exp == 8'hFF) && (a_frac == 23'h0);
      b_inf    = (b_exp == 8'hFF) && (b_frac == 23'h0);
      a_zero   = (a_exp == 8'h00);
      b_zero   = (b_exp == 8'h00);
      spec_hit = 1'b1;
      spec_val = 32'h0;
      if (a_nan || b_nan || (a_zero && b_zero) || (a_inf && b_inf)) begin
         spec_val = NAN_VALUE;
      end else if (a_inf || b_zero) begin
         spec_val = {sign_in, 8'hFF, 23'h0};
      end else if (a_zero || b_inf) begin
         spec_val = {sign_in, 31'h0};
      end else begin
         spec_hit = 1'b0;
      end
   end

   // One restoring step; the remainder entering a step is always below 2^24 after the compare.
   logic        rem_ge;
   logic [24:0] rem_diff;
   logic [24:0] rem_step;

   always_comb begin
      rem_ge   = (rem_r >= {1'b0, mb_r});
      rem_diff = rem_r - {1'b0, mb_r};
      rem_step = rem_ge ? {rem_diff[23:0], 1'b0} : {rem_r[23:0], 1'b0};
   end

   logic signed [9:0] e_norm;
   logic [22:0]       m_norm;
   logic [31:0]       norm_val;

   always_comb begin
      e_norm = $signed({2'b00, ea_r}) - $signed({2'b00, eb_r}) + 10'sd127
               - (quo_r[24] ? 10'sd0 : 10'sd1);
      m_norm = quo_r[24] ? quo_r[23:1] : quo_r[22:0];
      if (e_norm >= 10'sd255) begin
         norm_val = {sign_r, 8'hFF, 23'h0};
      end else if (e_norm <= 10'sd0) begin
         norm_val = {sign_r, 31'h0};
      end else begin
         norm_val = {sign_r, e_norm[7:0], m_norm};
      end
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (bus.in_valid) state_nxt = spec_hit ? DONE : DIVIDE;
         DIVIDE:  if (cnt_r == 5'd24) state_nxt = NORM;
         NORM:    state_nxt = DONE;
         DONE:    if (out_valid_r && bus.out_ready) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         sign_r      <= 1'b0;
         ea_r        <= 8'h0;
         eb_r        <= 8'h0;
         mb_r        <= 24'h0;
         rem_r       <= 25'h0;
         quo_r       <= 25'h0;
         cnt_r       <= 5'h0;
         res_r       <= 32'h0;
         out_r       <= 32'h0;
         out_valid_r <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (bus.in_valid) begin
                  sign_r <= sign_in;
                  ea_r   <= a_exp;
                  eb_r   <= b_exp;
                  mb_r   <= {1'b1, b_frac};
                  rem_r  <= {2'b01, a_frac};
                  quo_r  <= 25'h0;
                  cnt_r  <= 5'h0;
                  if (spec_hit) res_r <= spec_val;
               end
            end
            DIVIDE: begin
               rem_r <= rem_step;
               quo_r <= {quo_r[23:0], rem_ge};
               cnt_r <= cnt_r + 5'd1;
            end
            NORM: begin
               res_r <= norm_val;
            end
            DONE: begin
               // Output only changes together with the rising out_valid, then holds until taken.
               if (!out_valid_r) begin
                  out_valid_r <= 1'b1;
                  out_r       <= res_r;
               end else if (bus.out_ready) begin
                  out_valid_r <= 1'b0;
               end
            end
            default: ;
         endcase
      end
   end

   assign bus.in_ready  = (state == IDLE);
   assign bus.busy      = (state != IDLE);
   assign bus.out_valid = out_valid_r;
   assign bus.Output    = out_r;

endmodule
